lru_set_array: RTL and testbench
================================

# lru_set_array

Parametrised true-LRU replacement tracker for a set-associative cache. It holds one full recency stack per set for `SETS` sets of `WAYS` ways each. It supports hit/fill updates ("touch") and invalidation demotion ("demote"), and answers registered per-set LRU/MRU queries with one-cycle latency. The cache controller uses it to pick victim ways on fill and to keep invalidated ways first in line for reuse.

## Interface
- `SETS`, default 16: number of sets; any value ≥ 1.
- `WAYS`, default 4: ways per set; power of two, ≥ 2.
- `SET_W`, default `$clog2(SETS)` (min 1): set index width.
- `WAY_W`, default `$clog2(WAYS)`: way index width.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `touch_valid`, input, 1: make `touch_way` the MRU way of `touch_set`.
- `touch_set`, input, `SET_W`: set index for touch.
- `touch_way`, input, `WAY_W`: accessed way.
- `demote_valid`, input, 1: make `demote_way` the LRU way of `demote_set`.
- `demote_set`, input, `SET_W`: set index for demote.
- `demote_way`, input, `WAY_W`: invalidated way.
- `query_valid`, input, 1: request the replacement info for `query_set`.
- `query_set`, input, `SET_W`: set to query.
- `resp_valid`, output, 1: response strobe, registered.
- `resp_lru_way`, output, `WAY_W`: LRU way of the queried set, registered.
- `resp_mru_way`, output, `WAY_W`: MRU way of the queried set, registered.

## Operation
- **State per set:** ordered stack `s[0..WAYS-1]`. `s[0]` is MRU and `s[WAYS-1]` is LRU. The stack is always a permutation of `0..WAYS-1`.
- **Reset:** every set is loaded with `s[i] = i`, giving MRU = 0 and LRU = `WAYS-1`. Reset is a single cycle, with no init sweep.
- **Touch** (way `w` at stack position `p`):
  - positions `1..p` take the old contents of `0..p-1`;
  - `s[0] = w`;
  - positions above `p` are unchanged;
  - if `p = 0`, the set is unchanged.
- **Demote** (way `w` at position `p`):
  - positions `p..WAYS-2` take the old contents of `p+1..WAYS-1`;
  - `s[WAYS-1] = w`;
  - if `p = WAYS-1`, the set is unchanged.
- **Touch and demote to different sets in the same cycle:** both apply.
- **Touch and demote to the same set in the same cycle:** touch wins and the demote is dropped, with no error flag.
- **Out-of-range index** (`set ≥ SETS`, only possible when `SETS` is not a power of two):
  - on touch or demote, the operation is ignored;
  - on query, the response is still issued with `resp_lru_way = WAYS-1` and `resp_mru_way = 0`.
- **Query:** reads the stack of `query_set` as it stands before any update in the same cycle. There is no bypass of same-cycle updates.
- **No back-pressure:** one touch, one demote and one query can be accepted every cycle.

## Timing
- Update latency: a touch or demote sampled at edge N is visible to a query sampled at edge N+1 or later.
- Query latency: 1 cycle. A query sampled at edge N drives `resp_*` valid after edge N. `resp_valid` is high for exactly one cycle per query and stays high across back-to-back queries.
- When `query_valid` is low, `resp_valid` goes low and `resp_lru_way`/`resp_mru_way` hold their last value.
- Reset values:
  - `resp_valid` = 0;
  - `resp_lru_way` = `WAYS-1`;
  - `resp_mru_way` = 0;
  - all stacks in identity order.
- Reset mid-operation: `rst` overrides any touch, demote or query in the same cycle. No response is produced for a query sampled together with `rst`.
- Invariant: after any sequence of operations, each set's stack is a permutation.

## Test plan
- **Reset state:** defaults (`WAYS=4`); release reset, query set 5 → `resp_valid` = 1 one cycle later, LRU = 3, MRU = 0.
- **Touch ordering:**
  - stimulus: touch set 2 with ways 3, 1, 3, 0 in consecutive cycles, then query set 2;
  - required stack: [0, 3, 1, 2], so LRU = 2, MRU = 0;
  - set 3 is unaffected (LRU = 3).
- **Demote:** from that state, demote way 0 in set 2 → stack [3, 1, 2, 0], LRU = 0, MRU = 3. Demoting way 0 again leaves the set unchanged.
- **Simultaneous events:**
  - same cycle: touch set 4 way 3 and demote set 4 way 0 → set 4 stack [3, 0, 1, 2] (demote dropped);
  - touch set 6 way 2 and demote set 7 way 0 in one cycle → both apply.
- **Query/update collision:** query set 1 in the same cycle as touch set 1 way 3 → response shows old MRU = 0; a query the next cycle shows MRU = 3.
- **Mid-operation reset and random check:**
  - assert `rst` during traffic → all sets return to identity and `resp_valid` is 0;
  - random traffic at `WAYS=8`, `SETS=12` checked against a reference model with the permutation invariant;
  - out-of-range index 13 is ignored for touch and demote.

Source files
------------

// File: rtl/lru_set_array.sv
// True-LRU recency stacks, one per cache set, with touch/demote updates
// and a registered one-cycle LRU/MRU query port.
module lru_set_array #(
    parameter int SETS  = 16,
    parameter int WAYS  = 4,
    parameter int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_valid,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             demote_valid,
    input  logic [SET_W-1:0] demote_set,
    input  logic [WAY_W-1:0] demote_way,
    input  logic             query_valid,
    input  logic [SET_W-1:0] query_set,
    output logic             resp_valid,
    output logic [WAY_W-1:0] resp_lru_way,
    output logic [WAY_W-1:0] resp_mru_way
);

    typedef logic [WAYS-1:0][WAY_W-1:0] stack_t;

    localparam logic [SET_W:0] LP_SETS = (SET_W+1)'(SETS);

    stack_t           r_stack [SETS];
    logic             r_resp_valid;
    logic [WAY_W-1:0] r_resp_lru;
    logic [WAY_W-1:0] r_resp_mru;

    logic             w_t_inr;
    logic             w_d_inr;
    logic             w_q_inr;
    logic             w_t_hit;
    logic             w_d_hit;
    logic [SET_W-1:0] w_t_idx;
    logic [SET_W-1:0] w_d_idx;
    logic [SET_W-1:0] w_q_idx;
    stack_t           w_t_old;
    stack_t           w_t_new;
    stack_t           w_d_old;
    stack_t           w_d_new;
    stack_t           w_q_old;
    logic             w_t_seen;
    logic             w_d_seen;

    assign w_t_inr = {1'b0, touch_set}  < LP_SETS;
    assign w_d_inr = {1'b0, demote_set} < LP_SETS;
    assign w_q_inr = {1'b0, query_set}  < LP_SETS;
    assign w_t_hit = touch_valid  & w_t_inr;
    assign w_d_hit = demote_valid & w_d_inr;
    assign w_t_idx = w_t_inr ? touch_set  : '0;
    assign w_d_idx = w_d_inr ? demote_set : '0;
    assign w_q_idx = w_q_inr ? query_set  : '0;

    // Touch: entries above the hit position slide one step toward LRU.
    always_comb begin
        w_t_old    = r_stack[w_t_idx];
        w_t_new    = w_t_old;
        w_t_seen   = 1'b0;
        w_t_new[0] = touch_way;
        for (int i = 1; i < WAYS; i++) begin
            w_t_seen   = w_t_seen | (w_t_old[i-1] == touch_way);
            w_t_new[i] = w_t_seen ? w_t_old[i] : w_t_old[i-1];
        end
    end

    // Demote: entries below the hit position slide one step toward MRU.
    always_comb begin
        w_d_old         = r_stack[w_d_idx];
        w_d_new         = w_d_old;
        w_d_seen        = 1'b0;
        for (int i = 0; i < WAYS - 1; i++) begin
            w_d_seen   = w_d_seen | (w_d_old[i] == demote_way);
            w_d_new[i] = w_d_seen ? w_d_old[i+1] : w_d_old[i];
        end
        w_d_new[WAYS-1] = demote_way;
    end

    assign w_q_old = r_stack[w_q_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int i = 0; i < WAYS; i++) begin
                    r_stack[s][i] <= WAY_W'(i);
                end
            end
            r_resp_valid <= 1'b0;
            r_resp_lru   <= WAY_W'(WAYS - 1);
            r_resp_mru   <= '0;
        end else begin
            // Touch takes priority when both target the same set.
            for (int s = 0; s < SETS; s++) begin
                if (w_t_hit && touch_set == SET_W'(s)) begin
                    r_stack[s] <= w_t_new;
                end else if (w_d_hit && demote_set == SET_W'(s)) begin
                    r_stack[s] <= w_d_new;
                end
            end
            r_resp_valid <= query_valid;
            if (query_valid) begin
                if (w_q_inr) begin
                    r_resp_lru <= w_q_old[WAYS-1];
                    r_resp_mru <= w_q_old[0];
                end else begin
                    r_resp_lru <= WAY_W'(WAYS - 1);
                    r_resp_mru <= '0;
                end
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_lru_way = r_resp_lru;
    assign resp_mru_way = r_resp_mru;

endmodule

// File: tb/tb_lru_set_array.sv
// Directed checks on a 16x4 tracker plus model-checked traffic
// on a 12x8 tracker.
module tb_lru_set_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // ---- instance A: defaults (16 sets, 4 ways)
    logic       a_rst = 1'b1;
    logic       a_tv = 1'b0, a_dv = 1'b0, a_qv = 1'b0;
    logic [3:0] a_ts = '0, a_ds = '0, a_qs = '0;
    logic [1:0] a_tw = '0, a_dw = '0;
    logic       a_rv;
    logic [1:0] a_lru, a_mru;

    lru_set_array u_a (
        .clk(clk), .rst(a_rst),
        .touch_valid(a_tv), .touch_set(a_ts), .touch_way(a_tw),
        .demote_valid(a_dv), .demote_set(a_ds), .demote_way(a_dw),
        .query_valid(a_qv), .query_set(a_qs),
        .resp_valid(a_rv), .resp_lru_way(a_lru), .resp_mru_way(a_mru)
    );

    // ---- instance B: 12 sets, 8 ways
    logic       b_rst = 1'b1;
    logic       b_tv = 1'b0, b_dv = 1'b0, b_qv = 1'b0;
    logic [3:0] b_ts = '0, b_ds = '0, b_qs = '0;
    logic [2:0] b_tw = '0, b_dw = '0;
    logic       b_rv;
    logic [2:0] b_lru, b_mru;

    lru_set_array #(.SETS(12), .WAYS(8)) u_b (
        .clk(clk), .rst(b_rst),
        .touch_valid(b_tv), .touch_set(b_ts), .touch_way(b_tw),
        .demote_valid(b_dv), .demote_set(b_ds), .demote_way(b_dw),
        .query_valid(b_qv), .query_set(b_qs),
        .resp_valid(b_rv), .resp_lru_way(b_lru), .resp_mru_way(b_mru)
    );

    int m [12][8];

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_query(input int s, input int el, input int em,
                           input string tag);
        a_qv = 1'b1;
        a_qs = 4'(s);
        step();
        a_qv = 1'b0;
        chk({tag, ".v"}, int'(a_rv), 1);
        chk({tag, ".lru"}, int'(a_lru), el);
        chk({tag, ".mru"}, int'(a_mru), em);
    endtask

    task automatic a_touch(input int s, input int w);
        a_tv = 1'b1;
        a_ts = 4'(s);
        a_tw = 2'(w);
        step();
        a_tv = 1'b0;
    endtask

    task automatic a_demote(input int s, input int w);
        a_dv = 1'b1;
        a_ds = 4'(s);
        a_dw = 2'(w);
        step();
        a_dv = 1'b0;
    endtask

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < 8; i++) if (m[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m[s][i] = m[s][i-1];
        m[s][0] = w;
    endtask

    task automatic m_demote(input int s, input int w);
        int p = 0;
        for (int i = 0; i < 8; i++) if (m[s][i] == w) p = i;
        for (int i = p; i < 7; i++) m[s][i] = m[s][i+1];
        m[s][7] = w;
    endtask

    task automatic b_full_check(input string tag);
        for (int s = 0; s < 12; s++) begin
            int mask = 0;
            for (int i = 0; i < 8; i++) begin
                mask |= 1 << u_b.r_stack[s][i];
                chk({tag, ".stk"}, int'(u_b.r_stack[s][i]), m[s][i]);
            end
            chk({tag, ".perm"}, mask, 255);
        end
    endtask

    initial begin
        // ---------------- A: reset state
        step();
        step();
        chk("rst.v", int'(a_rv), 0);
        chk("rst.lru", int'(a_lru), 3);
        chk("rst.mru", int'(a_mru), 0);
        a_rst = 1'b0;
        a_query(5, 3, 0, "q5");
        step();
        chk("idle.v", int'(a_rv), 0);
        chk("idle.hold", int'(a_lru), 3);

        // touch ordering -> set 2 = [0,3,1,2]
        a_touch(2, 3);
        a_touch(2, 1);
        a_touch(2, 3);
        a_touch(2, 0);
        a_query(2, 2, 0, "touch2");
        a_query(3, 3, 0, "set3");

        // demote -> [3,1,2,0], then repeat is a no-op
        a_demote(2, 0);
        a_query(2, 0, 3, "dem2");
        a_demote(2, 0);
        a_query(2, 0, 3, "dem2b");

        // same-set collision: touch wins -> [3,0,1,2]
        a_tv = 1'b1; a_ts = 4'd4; a_tw = 2'd3;
        a_dv = 1'b1; a_ds = 4'd4; a_dw = 2'd0;
        step();
        a_tv = 1'b0; a_dv = 1'b0;
        a_query(4, 2, 3, "same4");

        // different sets: set6 [2,0,1,3], set7 [1,2,3,0]
        a_tv = 1'b1; a_ts = 4'd6; a_tw = 2'd2;
        a_dv = 1'b1; a_ds = 4'd7; a_dw = 2'd0;
        step();
        a_tv = 1'b0; a_dv = 1'b0;
        a_query(6, 3, 2, "diff6");
        a_query(7, 0, 1, "diff7");

        // query sees pre-update state
        a_qv = 1'b1; a_qs = 4'd1;
        a_tv = 1'b1; a_ts = 4'd1; a_tw = 2'd3;
        step();
        a_tv = 1'b0; a_qv = 1'b0;
        chk("coll.v", int'(a_rv), 1);
        chk("coll.mru", int'(a_mru), 0);
        chk("coll.lru", int'(a_lru), 3);
        a_query(1, 2, 3, "coll2");

        // back-to-back queries keep resp_valid high
        a_qv = 1'b1; a_qs = 4'd2;
        step();
        chk("b2b1.v", int'(a_rv), 1);
        chk("b2b1.mru", int'(a_mru), 3);
        a_qs = 4'd6;
        step();
        a_qv = 1'b0;
        chk("b2b2.v", int'(a_rv), 1);
        chk("b2b2.mru", int'(a_mru), 2);

        // reset mid-traffic overrides everything
        a_rst = 1'b1;
        a_tv = 1'b1; a_ts = 4'd0; a_tw = 2'd1;
        a_qv = 1'b1; a_qs = 4'd2;
        step();
        a_rst = 1'b0; a_tv = 1'b0; a_qv = 1'b0;
        chk("mrst.v", int'(a_rv), 0);
        chk("mrst.lru", int'(a_lru), 3);
        chk("mrst.mru", int'(a_mru), 0);
        a_query(2, 3, 0, "mrst2");
        a_query(4, 3, 0, "mrst4");
        a_query(6, 3, 0, "mrst6");
        a_query(0, 3, 0, "mrst0");

        // ---------------- B: model-checked traffic
        for (int s = 0; s < 12; s++)
            for (int i = 0; i < 8; i++) m[s][i] = i;
        step();
        b_rst = 1'b0;
        b_full_check("brst");

        for (int c = 0; c < 600; c++) begin
            int ts, ds, qs, tw, dw, el, em;
            bit tv, dv, qv;
            tv = ($urandom_range(0, 3) != 0);
            dv = ($urandom_range(0, 2) == 0);
            qv = ($urandom_range(0, 1) == 1);
            ts = $urandom_range(0, 13);
            ds = ($urandom_range(0, 4) == 0) ? ts : $urandom_range(0, 13);
            qs = $urandom_range(0, 13);
            tw = $urandom_range(0, 7);
            dw = $urandom_range(0, 7);
            b_tv = tv; b_ts = 4'(ts); b_tw = 3'(tw);
            b_dv = dv; b_ds = 4'(ds); b_dw = 3'(dw);
            b_qv = qv; b_qs = 4'(qs);
            el = (qs < 12) ? m[qs][7] : 7;
            em = (qs < 12) ? m[qs][0] : 0;
            step();
            chk("rnd.v", int'(b_rv), int'(qv));
            if (qv) begin
                chk("rnd.lru", int'(b_lru), el);
                chk("rnd.mru", int'(b_mru), em);
            end
            if (tv && ts < 12) m_touch(ts, tw);
            if (dv && ds < 12 && !(tv && ts == ds)) m_demote(ds, dw);
        end
        b_tv = 1'b0; b_dv = 1'b0; b_qv = 1'b0;
        b_full_check("rnd");

        // out-of-range set 13 is ignored for updates
        b_tv = 1'b1; b_ts = 4'd13; b_tw = 3'd5;
        b_dv = 1'b1; b_ds = 4'd13; b_dw = 3'd0;
        b_qv = 1'b1; b_qs = 4'd13;
        step();
        b_tv = 1'b0; b_dv = 1'b0; b_qv = 1'b0;
        chk("oor.v", int'(b_rv), 1);
        chk("oor.lru", int'(b_lru), 7);
        chk("oor.mru", int'(b_mru), 0);
        b_full_check("oor");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
